branch_sequencer: RTL and testbench

- Initiator for the branch compare unit. Accepts one control-transfer request from decode: conditional branch, JAL or JALR.
- For conditional branches it drives the compare unit's start/done handshake and consumes its jump result. It computes the target and link address, then presents one redirect to fetch/writeback with backpressure.
- Sits between decode and the branch compare unit / PC register.

---
 rtl/branch_sequencer.sv | 173 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Control-transfer sequencer: accepts one BRANCH/JAL/JALR request, runs the compare-unit
// handshake for conditional branches and presents one redirect to fetch with backpressure.
module branch_sequencer #(
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        bu_start,
  output logic [31:0] bu_rs1,
  output logic [31:0] bu_rs2,
  output logic [2:0]  bu_funct3,
  input  logic        bu_done,
  input  logic        bu_jump,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic [31:0] link_addr,
  output logic        taken,
  output logic        misaligned,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JAL    = 2'b01;
  localparam logic [1:0] OP_JALR   = 2'b10;
  localparam int         CW        = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [31:0] target;
    logic [31:0] link;
    logic        taken;
    logic        mis;
    logic        ill;
  } result_t;

  // Full redirect result for one request; jump is only meaningful for BRANCH.
  function automatic result_t resolve(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [31:0] pc, input logic [31:0] imm,
                                      input logic [31:0] rs1, input logic jump);
    result_t r;
    r.link  = pc + 32'd4;
    r.ill   = (op == 2'b11) || (op == OP_BRANCH && f3[2:1] == 2'b01);
    r.taken = 1'b0;
    r.target = pc + 32'd4;
    if (!r.ill) begin
      case (op)
        OP_JAL:  begin r.taken = 1'b1; r.target = pc + imm; end
        OP_JALR: begin r.taken = 1'b1; r.target = (rs1 + imm) & ~32'h1; end
        default: begin r.taken = jump; r.target = jump ? pc + imm : pc + 32'd4; end
      endcase
    end
    r.mis = r.taken && (r.target[1:0] != 2'b00);
    return r;
  endfunction

  state_t         state_reg;
  logic [1:0]     op_reg;
  logic [2:0]     funct3_reg;
  logic [31:0]    pc_reg;
  logic [31:0]    imm_reg;
  logic [31:0]    rs1_reg;
  logic [31:0]    rs2_reg;
  logic [CW-1:0]  cnt_reg;

  result_t res_accept;
  result_t res_wait;
  result_t res_load;
  logic    branch_req;

  assign bu_rs1    = rs1_reg;
  assign bu_rs2    = rs2_reg;
  assign bu_funct3 = funct3_reg;

  always_comb begin
    branch_req = (req_op == OP_BRANCH) && (req_funct3[2:1] != 2'b01);
    res_accept = resolve(req_op, req_funct3, req_pc, req_imm, req_rs1, 1'b0);
    // A timeout resolves as not-taken, so the jump input is masked by bu_done.
    res_wait   = resolve(op_reg, funct3_reg, pc_reg, imm_reg, rs1_reg, bu_done && bu_jump);
    res_load   = (state_reg == IDLE) ? res_accept : res_wait;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      funct3_reg     <= '0;
      pc_reg         <= '0;
      imm_reg        <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      cnt_reg        <= '0;
      req_ready      <= 1'b1;
      bu_start       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      link_addr      <= '0;
      taken          <= 1'b0;
      misaligned     <= 1'b0;
      illegal        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg     <= req_op;
            funct3_reg <= req_funct3;
            pc_reg     <= req_pc;
            imm_reg    <= req_imm;
            rs1_reg    <= req_rs1;
            rs2_reg    <= req_rs2;
            req_ready  <= 1'b0;
            timeout    <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            if (branch_req) begin
              state_reg <= ISSUE;
              bu_start  <= 1'b1;
            end else begin
              state_reg      <= RESP;
              redirect_valid <= 1'b1;
              redirect_pc    <= res_load.target;
              link_addr      <= res_load.link;
              taken          <= res_load.taken;
              misaligned     <= res_load.mis;
              illegal        <= res_load.ill;
            end
          end
        end
        ISSUE: begin
          // bu_done here may be a stale level from the previous compare.
          state_reg <= WAIT;
          cnt_reg   <= '0;
        end
        WAIT: begin
          if (bu_done || cnt_reg == CW'(TIMEOUT - 1)) begin
            state_reg      <= RESP;
            bu_start       <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= res_load.target;
            link_addr      <= res_load.link;
            taken          <= res_load.taken;
            misaligned     <= res_load.mis;
            illegal        <= res_load.ill;
            timeout        <= !bu_done;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RESP: begin
          if (redirect_ready) begin
            state_reg      <= IDLE;
            redirect_valid <= 1'b0;
            req_ready      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized bench for branch_sequencer: the bench plays the compare unit and
// predicts each redirect and its cycle of arrival from the control-transfer rules.
module tb_branch_sequencer;

  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_pc = '0, req_imm = '0, req_rs1 = '0, req_rs2 = '0;
  logic        bu_start;
  logic [31:0] bu_rs1, bu_rs2;
  logic [2:0]  bu_funct3;
  logic        bu_done = 1'b0, bu_jump = 1'b0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc, link_addr;
  logic        taken, misaligned, illegal, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_funct3(req_funct3),
    .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .bu_start(bu_start), .bu_rs1(bu_rs1), .bu_rs2(bu_rs2), .bu_funct3(bu_funct3),
    .bu_done(bu_done), .bu_jump(bu_jump),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .link_addr(link_addr), .taken(taken),
    .misaligned(misaligned), .illegal(illegal), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: op/operands, k = WAIT cycles before done (>= TIMEOUT means never),
  // jump = compare result, bp = cycles of redirect backpressure.
  task automatic do_txn(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int k, input logic jump, input int bp);
    logic        e_ill, e_taken, e_tmo, e_mis, is_branch;
    logic [31:0] e_pc, e_link, sum;
    int          r, guard;

    guard = 0;
    while (req_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) check("req_ready_wait", {31'b0, req_ready}, 32'd1);

    // Reference: plain arithmetic from the control-transfer rules.
    e_ill     = (op == 2'd3) || (op == 2'd0 && (f3 == 3'd2 || f3 == 3'd3));
    is_branch = (op == 2'd0) && !e_ill;
    e_tmo     = is_branch && (k >= TIMEOUT);
    e_link    = pc + 32'd4;
    if (e_ill) begin
      e_taken = 1'b0; e_pc = pc + 32'd4;
    end else if (op == 2'd1) begin
      e_taken = 1'b1; e_pc = pc + imm;
    end else if (op == 2'd2) begin
      sum = rs1 + imm;
      e_taken = 1'b1; e_pc = sum - (sum % 2);
    end else begin
      e_taken = jump && !e_tmo;
      e_pc    = e_taken ? pc + imm : pc + 32'd4;
    end
    e_mis = e_taken && (e_pc % 4 != 0);
    if (!is_branch) r = 1;
    else if (e_tmo) r = 2 + TIMEOUT;
    else r = 3 + k;

    req_op = op; req_funct3 = f3; req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_pc = $urandom; req_imm = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;

    for (int c = 1; c <= r; c++) begin
      if (c > 1) @(negedge clk);
      check("bu_start", {31'b0, bu_start}, {31'b0, is_branch && c < r});
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, c == r});
      if (c == 1) begin
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (is_branch) begin
          check("timeout_cleared", {31'b0, timeout}, 32'd0);
          check("bu_rs1", bu_rs1, rs1);
          check("bu_rs2", bu_rs2, rs2);
          check("bu_funct3", {29'b0, bu_funct3}, {29'b0, f3});
        end
      end
      if (c == r) begin
        bu_done = 1'b0;
      end else if (c == 1) begin
        bu_done = 1'b1;               // stale done during ISSUE must be ignored
        bu_jump = $urandom_range(0, 1);
      end else begin
        bu_done = (c - 2 == k);
        bu_jump = (c - 2 == k) ? jump : 1'($urandom_range(0, 1));
      end
    end

    check("redirect_pc", redirect_pc, e_pc);
    check("link_addr", link_addr, e_link);
    check("taken", {31'b0, taken}, {31'b0, e_taken});
    check("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
    check("illegal", {31'b0, illegal}, {31'b0, e_ill});
    check("timeout", {31'b0, timeout}, {31'b0, e_tmo});
    $display("txn op=%0d f3=%0d pc=%h imm=%h rs1=%h k=%0d jump=%0d bp=%0d -> pc=%h taken=%0d mis=%0d ill=%0d tmo=%0d",
             op, f3, pc, imm, rs1, k, jump, bp, redirect_pc, taken, misaligned, illegal, timeout);

    for (int b = 0; b < bp; b++) begin
      req_valid = 1'b1;
      req_op = 2'($urandom); req_funct3 = 3'($urandom);
      @(negedge clk);
      check("bp_valid", {31'b0, redirect_valid}, 32'd1);
      check("bp_pc", redirect_pc, e_pc);
      check("bp_taken", {31'b0, taken}, {31'b0, e_taken});
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    check("valid_drop", {31'b0, redirect_valid}, 32'd0);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    check("sticky_timeout", {31'b0, timeout}, {31'b0, e_tmo});
  endtask

  initial begin
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_redirect_pc", redirect_pc, RESET_PC);
    check("rst_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_bu_start", {31'b0, bu_start}, 32'd0);
    check("rst_flags", {28'b0, taken, misaligned, illegal, timeout}, 32'd0);
    check("rst_bu_rs1", bu_rs1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_txn(2'd0, 3'b000, 32'h100, 32'h40, 32'h5, 32'h5, 1, 1'b1, 0);      // BEQ taken at N+4
    do_txn(2'd0, 3'b001, 32'h100, 32'h40, 32'h5, 32'h5, 2, 1'b0, 0);      // BNE not taken
    do_txn(2'd2, 3'b000, 32'h300, 32'h10, 32'h2001, 32'h0, 0, 1'b0, 0);   // JALR clears bit0
    do_txn(2'd1, 3'b000, 32'h200, 32'h6, 32'h0, 32'h0, 0, 1'b0, 0);       // JAL misaligned
    do_txn(2'd0, 3'b100, 32'h400, 32'h80, 32'h1, 32'h2, 99, 1'b1, 0);     // timeout
    do_txn(2'd1, 3'b000, 32'h500, 32'h8, 32'h0, 32'h0, 0, 1'b0, 5);       // clears timeout, backpressure
    do_txn(2'd0, 3'b010, 32'h600, 32'h20, 32'h0, 32'h0, 0, 1'b1, 0);      // illegal funct3
    do_txn(2'd3, 3'b000, 32'h700, 32'h20, 32'h0, 32'h0, 0, 1'b1, 1);      // reserved op
    do_txn(2'd1, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 0, 1'b0, 0); // wrap to 0x4
    do_txn(2'd0, 3'b101, 32'h800, 32'h0, 32'h0, 32'h0, TIMEOUT - 1, 1'b1, 2); // done on last WAIT cycle

    // Asynchronous reset in the middle of WAIT.
    req_op = 2'd0; req_funct3 = 3'b000; req_pc = 32'h900; req_imm = 32'h10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    bu_done = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_bu_start", {31'b0, bu_start}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_bu_start", {31'b0, bu_start}, 32'd0);
    check("arst_valid", {31'b0, redirect_valid}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    check("arst_redirect_pc", redirect_pc, RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'b0, redirect_valid}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ipc, iimm;
      ipc  = $urandom;
      iimm = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 64)) - 32'd32;
      do_txn(2'($urandom), 3'($urandom), ipc, iimm, $urandom, $urandom,
             $urandom_range(0, TIMEOUT + 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
